vga_fb_scanout_arbiter: RTL and testbench
=========================================

Name: vga_fb_scanout_arbiter

Overview:
- Shares one single-port framebuffer SRAM between display scanout (reads) and a host/drawing write port.
- Prefetches pixels, row-major from address 0, into a pixel FIFO that drains on the timing generator's display enable.
- Host writes are serviced in slots that scanout does not urgently need.
- Sits between the 640x480 VGA timing generator, the framebuffer SRAM and the pixel output stage.

Parameters:
- DATA_W, 8, pixel width; one SRAM word holds one pixel.
- ADDR_W, 19, SRAM word address width.
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines.
- FIFO_DEPTH, 16, pixel FIFO entries; power of 2, at least 4.
- LOW_WATER, 6, reads go urgent when fifo_level + inflight < LOW_WATER.
- RD_LAT, 2, cycles from mem_en (read) output to valid mem_rdata; at least 1.
- UNDERRUN_PIX, 8'h00, pixel driven on underrun.

Ports:
- clk, in, 1: 25 MHz pixel clock.
- rst_n, in, 1: asynchronous active-low reset.
- display_en, in, 1: pop request for one pixel (timing generator visible-area flag).
- vblank_start, in, 1: one-cycle pulse at the first blanking line; restarts the frame.
- pix_data, out, DATA_W: registered pixel to output stage.
- underrun, out, 1: sticky flag, set on a pop from an empty FIFO.
- host_valid, in, 1: host write request.
- host_ready, out, 1: write accepted when host_valid && host_ready.
- host_addr, in, ADDR_W: write word address.
- host_wdata, in, DATA_W: write data.
- mem_en, out, 1: registered SRAM access strobe.
- mem_we, out, 1: 1 = write, 0 = read.
- mem_addr, out, ADDR_W: SRAM address.
- mem_wdata, out, DATA_W: SRAM write data.
- mem_rdata, in, DATA_W: SRAM read data, valid RD_LAT cycles after a read strobe.

Behaviour:
- Reset values: all outputs 0; fetch_addr 0; FIFO empty; read pipe empty; FSM in FETCH.
- FSM FETCH:
  - fetch_want = (fifo_level + inflight < FIFO_DEPTH).
  - inflight counts reads in the command register plus the RD_LAT valid-shift pipe.
- Per-cycle decision (registered onto mem_* next cycle):
  - Urgent fetch: read at fetch_addr.
  - Else host_valid && host_ready: write.
  - Else fetch_want: read.
  - Else mem_en = 0 next cycle.
- host_ready = !(state == FETCH && urgent). It depends on registered state only, never on host_valid.
- Each issued read increments fetch_addr. The read issuing address H_ACTIVE*V_ACTIVE-1 moves the FSM to DONE.
- FSM DONE: no reads; every cycle is available to the host (host_ready = 1).
- Read return: a valid bit travels through the RD_LAT shift pipe; at its tail, mem_rdata is pushed into the FIFO. FIFO cannot overflow by construction; an overflow is an assertion failure.
- Pop on display_en:
  - FIFO non-empty: pix_data <= head, registered, one-cycle latency.
  - FIFO empty: pix_data <= UNDERRUN_PIX and underrun <= 1.
  - display_en low: pix_data holds.
- Same-cycle push and pop are both honoured; level unchanged.
- vblank_start, from any state, takes priority over all other events in that cycle:
  - FIFO flushed; read-pipe valid bits cleared, so in-flight data is discarded.
  - fetch_addr <= 0; FSM -> FETCH; underrun cleared.
  - A host write accepted in the same cycle still completes.
- vblank_start coincident with display_en: the pop is ignored.
- Address arithmetic is unsigned ADDR_W; fetch_addr never exceeds H_ACTIVE*V_ACTIVE-1.
- Reset mid-operation: immediate return to reset values; SRAM contents are untouched.

Decomposition:
- Package vga_fb_pkg: DATA_W/ADDR_W defaults, FRAME_WORDS = H_ACTIVE*V_ACTIVE, fetch-state enum (FETCH, DONE), UNDERRUN_PIX.
- One sub-module: vga_pixel_fifo, a synchronous FIFO with push/pop/flush/level outputs, FIFO_DEPTH entries.

Test Plan:
- Reset, then no display_en, no host traffic: exactly 16 reads issued (addr 0..15), then mem_en stays 0. level = 16, host_ready = 1.
- SRAM model returns data = addr[7:0]; display_en held 640 cycles: pix_data sequence 0x00..0x7F and onward, underrun stays 0.
- host_valid held high with the FIFO full: writes issue every cycle at host_addr. When the level drops to 5 (urgent), host_ready = 0 and a read is issued next cycle.
- Drive display_en with an empty FIFO (SRAM model stalled via large RD_LAT): pix_data = 0x00, underrun = 1 and sticky until vblank_start.
- Fetch through address 307199: state DONE, no further reads, host_ready = 1. vblank_start, then the next read is at address 0.
- vblank_start with 2 reads in flight: returned data is discarded, level = 0 the next cycle, refetch restarts at address 0.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared defaults and types for the framebuffer scanout arbiter.
package vga_fb_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 19;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int FRAME_WORDS = H_ACTIVE_DEF * V_ACTIVE_DEF;
  localparam logic [DATA_W_DEF-1:0] UNDERRUN_PIX = 8'h00;
  typedef enum logic {FETCH, DONE} fetch_state_e;
endpackage

// File: rtl/vga_pixel_fifo.sv
// vga_pixel_fifo: synchronous pixel FIFO with flush and fill-level output.
module vga_pixel_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [AW:0]       level_o,
  output logic              empty_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] level_q, level_d;
  logic do_pop;
  assign empty_o = level_q == '0;
  assign do_pop = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q];
  assign level_o = level_q;
  always_comb begin
    wr_d = flush_i ? '0 : wr_q + AW'(push_i);
    rd_d = flush_i ? '0 : rd_q + AW'(do_pop);
    level_d = flush_i ? '0 : level_q + (AW+1)'(push_i) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
    end
  always_ff @(posedge clk)
    if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
  // Read credit accounting upstream makes a push into a full FIFO impossible.
  always_ff @(posedge clk)
    if (rst_n && push_i && !flush_i) assert (do_pop || level_q != (AW+1)'(DEPTH));
endmodule

// File: rtl/vga_fb_scanout_arbiter.sv
// vga_fb_scanout_arbiter: shares one framebuffer SRAM between scanout prefetch
// and host writes; urgent refills win, otherwise the host goes first.
module vga_fb_scanout_arbiter
  import vga_fb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WATER = 6,
  parameter int RD_LAT = 2,
  parameter logic [DATA_W-1:0] UNDERRUN_PIX = vga_fb_pkg::UNDERRUN_PIX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              display_en,
  input  logic              vblank_start,
  output logic [DATA_W-1:0] pix_data,
  output logic              underrun,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(FIFO_DEPTH + RD_LAT + 2);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d, mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, pix_q, pix_d, head;
  logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic mem_en_q, mem_en_d, mem_we_q, mem_we_d, underrun_q, underrun_d;
  logic [LW-1:0] level;
  logic [SW-1:0] sum;
  logic empty, cmd_rd, urgent, want, wr, rd, pop, last;
  assign cmd_rd = mem_en_q && !mem_we_q;
  // Credit = buffered pixels plus every read not yet returned.
  always_comb begin
    sum = SW'(level) + SW'(cmd_rd);
    for (int i = 0; i < RD_LAT; i++) sum = sum + SW'(rd_pipe_q[i]);
  end
  assign urgent = state_q == FETCH && sum < SW'(LOW_WATER);
  assign want = state_q == FETCH && sum < SW'(FIFO_DEPTH);
  assign host_ready = !urgent;
  assign wr = host_valid && host_ready;
  assign rd = !vblank_start && (urgent || (want && !wr));
  assign pop = display_en && !vblank_start;
  assign last = fetch_addr_q == LAST_ADDR;
  always_comb begin
    state_d = vblank_start ? FETCH : (rd && last) ? DONE : state_q;
    fetch_addr_d = vblank_start ? '0 : (rd && !last) ? fetch_addr_q + ADDR_W'(1) : fetch_addr_q;
    mem_en_d = rd || wr;
    mem_we_d = wr;
    mem_addr_d = rd ? fetch_addr_q : wr ? host_addr : mem_addr_q;
    mem_wdata_d = wr ? host_wdata : mem_wdata_q;
    rd_pipe_d = vblank_start ? '0 : RD_LAT'({rd_pipe_q, cmd_rd});
    pix_d = !pop ? pix_q : empty ? UNDERRUN_PIX : head;
    underrun_d = !vblank_start && (underrun_q || (pop && empty));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= FETCH;
      fetch_addr_q <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      rd_pipe_q <= '0;
      pix_q <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_addr_q <= fetch_addr_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_pipe_q <= rd_pipe_d;
      pix_q <= pix_d;
      underrun_q <= underrun_d;
    end
  vga_pixel_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rd_pipe_q[RD_LAT-1]),
    .pop_i   (pop),
    .flush_i (vblank_start),
    .wdata_i (mem_rdata),
    .rdata_o (head),
    .level_o (level),
    .empty_o (empty)
  );
  assign pix_data = pix_q;
  assign underrun = underrun_q;
  assign mem_en = mem_en_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_vga_fb_scanout_arbiter.sv
// tb_vga_fb_scanout_arbiter: scoreboard bench; stimulus queues expected pixels
// and writes, a negedge monitor checks them and the sequential read addresses.
module tb_vga_fb_scanout_arbiter;
  import vga_fb_pkg::*;
  localparam int DW = 8, AW = 19, RDL = 2, VA = 4, FRAME = H_ACTIVE_DEF * VA;
  logic clk = 1'b0, rst_n = 1'b1, display_en = 1'b0, vblank_start = 1'b0, host_valid = 1'b0;
  logic [AW-1:0] host_addr = '0, mem_addr;
  logic [DW-1:0] host_wdata = '0, pix_data, mem_wdata, mem_rdata;
  logic underrun, host_ready, mem_en, mem_we;
  logic [DW-1:0] sram_pipe [RDL];
  logic [DW-1:0] exp_pix_q [$];
  logic [AW+DW-1:0] exp_wr_q [$];
  int n_chk = 0, n_fail = 0, exp_rd = 0, rd_cnt = 0, wr_cnt = 0, pix_idx = 0, base;
  logic pend_pop = 1'b0;
  always #5 clk = ~clk;
  vga_fb_scanout_arbiter #(.V_ACTIVE(VA), .RD_LAT(RDL)) dut (
    .clk(clk), .rst_n(rst_n), .display_en(display_en), .vblank_start(vblank_start),
    .pix_data(pix_data), .underrun(underrun), .host_valid(host_valid), .host_ready(host_ready),
    .host_addr(host_addr), .host_wdata(host_wdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  // SRAM model: every word reads back as the low byte of its address.
  always @(posedge clk) begin
    sram_pipe[0] <= mem_addr[7:0];
    for (int i = 1; i < RDL; i++) sram_pipe[i] <= sram_pipe[i-1];
  end
  assign mem_rdata = sram_pipe[RDL-1];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask
  task automatic extra(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: actual unexpected output required none", nm);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_rd = 0;
      pend_pop = 1'b0;
    end else begin
      if (pend_pop) begin
        if (exp_pix_q.size() == 0) extra("pix_extra");
        else chk("pix_data", pix_data, exp_pix_q.pop_front());
      end
      pend_pop = display_en && !vblank_start;
      if (mem_en && !mem_we) begin
        rd_cnt++;
        chk("rd_addr", mem_addr, exp_rd);
        chk("rd_in_frame", exp_rd < FRAME, 1);
        exp_rd++;
      end
      if (mem_en && mem_we) begin
        wr_cnt++;
        if (exp_wr_q.size() == 0) extra("wr_extra");
        else chk("wr_addr_data", {mem_addr, mem_wdata}, exp_wr_q.pop_front());
      end
      if (vblank_start) exp_rd = 0;
    end
  end
  initial begin
    #1 rst_n = 1'b0;
    repeat (3) step();
    chk("rst_pix", pix_data, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_host_ready", host_ready, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    repeat (40) step();
    chk("idle_reads", rd_cnt, 16);
    chk("idle_mem_en", mem_en, 0);
    chk("idle_host_ready", host_ready, 1);
    display_en = 1'b1;
    for (int k = 0; k < 640; k++) begin
      exp_pix_q.push_back(DW'(pix_idx));
      pix_idx++;
      step();
    end
    display_en = 1'b0;
    chk("line_underrun", underrun, 0);
    repeat (30) step();
    for (int k = 0; k < 14; k++) begin
      display_en = 1'b1;
      host_valid = 1'b1;
      host_addr = AW'(32'h40000 + k);
      host_wdata = DW'(8'hA0 + k);
      exp_pix_q.push_back(DW'(pix_idx));
      pix_idx++;
      chk("hr_drain", host_ready, k < 11);
      if (host_ready) exp_wr_q.push_back({host_addr, host_wdata});
      if (k == 11) chk("last_write", {mem_en, mem_we}, 2'b11);
      if (k == 12) chk("urgent_read", {mem_en, mem_we}, 2'b10);
      step();
    end
    display_en = 1'b0;
    host_valid = 1'b0;
    repeat (30) step();
    chk("wr_count", wr_cnt, 11);
    display_en = 1'b1;
    while (pix_idx < FRAME + 3) begin
      if (pix_idx == FRAME) chk("no_early_underrun", underrun, 0);
      exp_pix_q.push_back(pix_idx < FRAME ? DW'(pix_idx) : 8'h00);
      pix_idx++;
      step();
    end
    display_en = 1'b0;
    repeat (5) step();
    chk("underrun_set", underrun, 1);
    chk("done_host_ready", host_ready, 1);
    chk("frame_reads", rd_cnt, FRAME);
    chk("done_idle", mem_en, 0);
    host_valid = 1'b1;
    host_addr = 19'h7FFFF;
    host_wdata = 8'h5A;
    chk("done_write_ready", host_ready, 1);
    if (host_ready) exp_wr_q.push_back({host_addr, host_wdata});
    step();
    host_valid = 1'b0;
    repeat (3) step();
    chk("wr_count_done", wr_cnt, 12);
    chk("underrun_sticky", underrun, 1);
    vblank_start = 1'b1;
    step();
    vblank_start = 1'b0;
    pix_idx = 0;
    chk("vb_underrun_clr", underrun, 0);
    chk("vb_urgent", host_ready, 0);
    step();
    chk("vb_first_read", {mem_en, mem_we, mem_addr}, {2'b10, {AW{1'b0}}});
    step();
    vblank_start = 1'b1;
    step();
    vblank_start = 1'b0;
    step();
    chk("refetch_addr0", {mem_en, mem_we, mem_addr}, {2'b10, {AW{1'b0}}});
    display_en = 1'b1;
    exp_pix_q.push_back(8'h00);
    step();
    display_en = 1'b0;
    chk("flush_underrun", underrun, 1);
    repeat (30) step();
    display_en = 1'b1;
    for (int k = 0; k < 24; k++) begin
      exp_pix_q.push_back(DW'(pix_idx));
      pix_idx++;
      step();
    end
    display_en = 1'b0;
    step();
    chk("underrun_sticky2", underrun, 1);
    chk("pix_drained", exp_pix_q.size(), 0);
    chk("wr_drained", exp_wr_q.size(), 0);
    rst_n = 1'b0;
    base = rd_cnt;
    #2;
    chk("arst_pix", pix_data, 0);
    chk("arst_underrun", underrun, 0);
    chk("arst_mem_en", mem_en, 0);
    chk("arst_mem_wdata", mem_wdata, 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (40) step();
    chk("post_reset_reads", rd_cnt - base, 16);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
